bullet_unit: RTL and testbench

Player-projectile controller for the Space Invaders datapath. It launches one bullet from the spaceship on `fire`, moves it upward by `speed` pixels per video frame, and retires it when it leaves the top of the screen. It also tells the pixel mux when the current raster position lies on the bullet. It sits between the spaceship block, which supplies the spawn position, and the video compositor, which consumes `drawing` and `pixel`. Collision logic reads `bullet_x`/`bullet_y`.

---
 rtl/game_pkg.sv | 15 +
 rtl/rect_hit.sv | 21 ++
 rtl/bullet_unit.sv | 87 ++++++++
 tb/tb_bullet_unit.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/game_pkg.sv
// rtl/game_pkg.sv - shared sprite types and defaults for the game datapath
package game_pkg;

  typedef logic signed [15:0] coord_t;

  typedef enum logic [3:0] {
    ST_IDLE    = 4'b0001,
    ST_LAUNCH  = 4'b0010,
    ST_MOVING  = 4'b0100,
    ST_EXPIRED = 4'b1000
  } bullet_state_t;

  localparam logic [3:0] DEFAULT_COLOR = 4'hF;

endpackage

// File: rtl/rect_hit.sv
// rtl/rect_hit.sv - combinational signed point-in-rectangle test for sprites
module rect_hit
  import game_pkg::*;
(
  input  coord_t x,
  input  coord_t y,
  input  coord_t w,
  input  coord_t h,
  input  coord_t px,
  input  coord_t py,
  output logic   hit
);

  coord_t x_end;
  coord_t y_end;

  assign x_end = x + w;
  assign y_end = y + h;
  assign hit   = (px >= x) && (px < x_end) && (py >= y) && (py < y_end);

endmodule

// File: rtl/bullet_unit.sv
// rtl/bullet_unit.sv - player bullet launch, flight, retirement and raster hit
module bullet_unit
  import game_pkg::*;
#(
  parameter int         BULLET_W = 2,
  parameter int         BULLET_H = 8,
  parameter int         SHIP_W   = 16,
  parameter logic [3:0] COLOR    = DEFAULT_COLOR
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               fire,
  input  logic               frame,
  input  logic               screen_line,
  input  logic [7:0]         speed,
  input  logic signed [15:0] screen_x,
  input  logic signed [15:0] screen_y,
  input  logic signed [15:0] spaceship_x,
  input  logic signed [15:0] spaceship_y,
  output logic               drawing,
  output logic [3:0]         pixel,
  output logic signed [15:0] bullet_x,
  output logic signed [15:0] bullet_y,
  output logic [3:0]         bullet_state
);

  localparam coord_t SPAWN_DX = coord_t'(SHIP_W / 2 - BULLET_W / 2);
  localparam coord_t BW       = coord_t'(BULLET_W);
  localparam coord_t BH       = coord_t'(BULLET_H);
  localparam coord_t EXPIRE_Y = -BH;

  bullet_state_t state;
  coord_t        next_y;
  logic          hit;
  logic          on_screen;
  logic          unused_line;

  assign unused_line  = screen_line;
  assign next_y       = bullet_y - coord_t'({8'b0, speed});
  assign on_screen    = hit && (state == ST_LAUNCH || state == ST_MOVING);
  assign bullet_state = state;

  rect_hit u_hit (
    .x  (bullet_x),
    .y  (bullet_y),
    .w  (BW),
    .h  (BH),
    .px (screen_x),
    .py (screen_y),
    .hit(hit)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      state    <= ST_IDLE;
      bullet_x <= '0;
      bullet_y <= '0;
      drawing  <= 1'b0;
      pixel    <= '0;
    end else begin
      drawing <= on_screen;
      pixel   <= on_screen ? COLOR : 4'h0;
      case (state)
        ST_IDLE: begin
          if (fire) begin
            state    <= ST_LAUNCH;
            bullet_x <= spaceship_x + SPAWN_DX;
            bullet_y <= spaceship_y - BH;
          end
        end
        ST_LAUNCH: begin
          // The entering strobe only arms flight; movement starts on the next one.
          if (frame) state <= ST_MOVING;
        end
        ST_MOVING: begin
          if (frame) begin
            bullet_y <= next_y;
            if (next_y <= EXPIRE_Y) state <= ST_EXPIRED;
          end
        end
        ST_EXPIRED: state <= ST_IDLE;
        default:    state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bullet_unit.sv
// tb/tb_bullet_unit.sv - randomized model-checked bench for bullet_unit
module tb_bullet_unit;

  logic               clk = 1'b0;
  logic               rst;
  logic               fire;
  logic               frame;
  logic               screen_line;
  logic [7:0]         speed;
  logic signed [15:0] screen_x;
  logic signed [15:0] screen_y;
  logic signed [15:0] spaceship_x;
  logic signed [15:0] spaceship_y;
  logic               drawing;
  logic [3:0]         pixel;
  logic signed [15:0] bullet_x;
  logic signed [15:0] bullet_y;
  logic [3:0]         bullet_state;

  int n_cmp = 0;
  int n_bad = 0;

  // Model: phase 0 idle, 1 launched, 2 flying, 3 expired; positions as plain ints.
  int m_phase = 0;
  int m_x = 0;
  int m_y = 0;
  bit m_drw = 0;
  bit m_valid = 0;

  bullet_unit dut (
    .clk(clk), .rst(rst), .fire(fire), .frame(frame), .screen_line(screen_line),
    .speed(speed), .screen_x(screen_x), .screen_y(screen_y),
    .spaceship_x(spaceship_x), .spaceship_y(spaceship_y),
    .drawing(drawing), .pixel(pixel), .bullet_x(bullet_x), .bullet_y(bullet_y),
    .bullet_state(bullet_state)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  always @(posedge clk) begin
    int sx, sy;
    sx = int'(screen_x);
    sy = int'(screen_y);
    if (!rst) begin
      m_phase = 0; m_x = 0; m_y = 0; m_drw = 0; m_valid = 1;
    end else begin
      m_drw = (m_phase == 1 || m_phase == 2) && sx >= m_x && sx < m_x + 2 &&
              sy >= m_y && sy < m_y + 8;
      case (m_phase)
        0: if (fire) begin
             m_phase = 1;
             m_x = int'(spaceship_x) + 16 / 2 - 2 / 2;
             m_y = int'(spaceship_y) - 8;
           end
        1: if (frame) m_phase = 2;
        2: if (frame) begin
             m_y = m_y - int'(speed);
             if (m_y <= -8) m_phase = 3;
           end
        default: m_phase = 0;
      endcase
    end
  end

  always @(negedge clk) begin
    if (m_valid) begin
      check("model_state", int'(bullet_state), 1 << m_phase);
      check("model_x", int'(bullet_x), m_x);
      check("model_y", int'(bullet_y), m_y);
      check("model_drawing", int'(drawing), int'(m_drw));
      check("model_pixel", int'(pixel), m_drw ? 15 : 0);
    end
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic strobe();
    frame = 1'b1;
    step(1);
    frame = 1'b0;
  endtask

  initial begin
    rst = 1'b0; fire = 1'b0; frame = 1'b0; screen_line = 1'b0; speed = 8'd1;
    screen_x = 16'sd0; screen_y = 16'sd0; spaceship_x = 16'sd10; spaceship_y = 16'sd10;
    step(2);
    check("reset_state", int'(bullet_state), 1);
    check("reset_x", int'(bullet_x), 0);
    check("reset_drawing", int'(drawing), 0);
    rst = 1'b1;

    // Launch and full flight with fire held high throughout.
    fire = 1'b1;
    step(1);
    check("launch_state", int'(bullet_state), 2);
    check("launch_x", int'(bullet_x), 17);
    check("launch_y", int'(bullet_y), 2);
    strobe();
    check("arm_state", int'(bullet_state), 4);
    check("arm_y", int'(bullet_y), 2);
    for (int k = 1; k <= 10; k++) begin
      strobe();
      check("flight_y", int'(bullet_y), 2 - k);
      check("flight_state", int'(bullet_state), (k == 10) ? 8 : 4);
      if (k < 10) step(1);
    end
    step(1);
    check("retire_state", int'(bullet_state), 1);
    step(1);
    check("refire_state", int'(bullet_state), 2);
    check("refire_x", int'(bullet_x), 17);
    check("refire_y", int'(bullet_y), 2);
    fire = 1'b0;
    strobe();

    // Raster hits around the bullet at (17,2).
    screen_x = 16'sd17; screen_y = 16'sd2; step(1);
    check("draw_17_2", int'(drawing), 1);
    check("pixel_17_2", int'(pixel), 15);
    screen_x = 16'sd18; screen_y = 16'sd9; step(1);
    check("draw_18_9", int'(drawing), 1);
    screen_x = 16'sd19; screen_y = 16'sd2; step(1);
    check("draw_19_2", int'(drawing), 0);
    screen_x = 16'sd17; screen_y = 16'sd10; step(1);
    check("draw_17_10", int'(drawing), 0);
    check("pixel_17_10", int'(pixel), 0);

    // Reset mid-flight with the raster on the bullet.
    screen_x = 16'sd17; screen_y = 16'sd2;
    rst = 1'b0; step(1); rst = 1'b1;
    check("abort_state", int'(bullet_state), 1);
    check("abort_x", int'(bullet_x), 0);
    check("abort_y", int'(bullet_y), 0);
    check("abort_drawing", int'(drawing), 0);
    fire = 1'b1; step(1); fire = 1'b0;
    check("relaunch_state", int'(bullet_state), 2);
    check("relaunch_x", int'(bullet_x), 17);

    // Fast bullet leaves on its first moving strobe.
    speed = 8'd200;
    strobe();
    strobe();
    check("fast_y", int'(bullet_y), -198);
    check("fast_state", int'(bullet_state), 8);
    screen_x = 16'sd17; screen_y = -16'sd198;
    step(1);
    check("fast_idle", int'(bullet_state), 1);
    step(1);
    check("idle_drawing", int'(drawing), 0);

    // Zero speed hovers forever.
    speed = 8'd0;
    fire = 1'b1; step(1); fire = 1'b0;
    strobe();
    for (int k = 0; k < 20; k++) begin
      strobe();
      check("hover_y", int'(bullet_y), 2);
      check("hover_state", int'(bullet_state), 4);
    end

    // Randomized traffic against the model.
    for (int i = 0; i < 4000; i++) begin
      rst   = ($urandom_range(0, 149) != 0);
      fire  = ($urandom_range(0, 7) == 0);
      frame = ($urandom_range(0, 2) == 0);
      screen_line = $urandom_range(0, 1) == 1;
      if ($urandom_range(0, 31) == 0)
        speed = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 255))
                                            : 8'($urandom_range(0, 12));
      spaceship_x = 16'(int'($urandom_range(0, 400)) - 100);
      spaceship_y = 16'(int'($urandom_range(0, 300)) - 50);
      screen_x = 16'(m_x + int'($urandom_range(0, 5)) - 2);
      screen_y = 16'(m_y + int'($urandom_range(0, 12)) - 2);
      step(1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
